// File: rtl/lsu_pkg.sv
// lsu_pkg -- shared constants and helpers for the load/store unit.
//   Region base addresses (12-bit decoded space), DMEM geometry,
//   byte_num lane-mask encodings, and the address-region decoder.
package lsu_pkg;

    localparam int DMEM_DEPTH = 512;
    localparam int DMEM_WIDTH = 32;
    localparam int DMEM_AW    = 9;

    localparam logic [11:0] DMEM_BASE = 12'h000;
    localparam logic [11:0] LEDR_BASE = 12'h800;
    localparam logic [11:0] LEDG_BASE = 12'h810;
    localparam logic [11:0] HEX0_BASE = 12'h820;
    localparam logic [11:0] LCD_BASE  = 12'h8A0;
    localparam logic [11:0] SW_BASE   = 12'h900;
    localparam logic [11:0] PUSH_BASE = 12'h910;

    // LEDR, LEDG, HEX0..HEX7, LCD
    localparam int NUM_OUT = 11;

    localparam logic [3:0] BN_BYTE = 4'b0001;
    localparam logic [3:0] BN_HALF = 4'b0011;
    localparam logic [3:0] BN_WORD = 4'b1111;

    typedef enum logic [2:0] {
        RGN_DMEM,
        RGN_OUT,
        RGN_SW,
        RGN_PUSH,
        RGN_NONE
    } region_e;

    // Output windows are 16 bytes apart starting at 0x800, so a[7:4] is the
    // register index (0 = LEDR ... 10 = LCD) whenever a[11:8] == 8.
    function automatic region_e decode(input logic [11:0] a);
        if (!a[11])
            return RGN_DMEM;
        else if (a[11:8] == LEDR_BASE[11:8] && a[7:4] <= LCD_BASE[7:4])
            return RGN_OUT;
        else if (a[11:4] == SW_BASE[11:4])
            return RGN_SW;
        else if (a[11:4] == PUSH_BASE[11:4])
            return RGN_PUSH;
        else
            return RGN_NONE;
    endfunction

endpackage

// File: rtl/lsu_dmem.sv
// lsu_dmem -- 512 x 32-bit data memory, little-endian byte lanes.
//   clk_i    : write clock
//   we_i     : write enable
//   be_i     : per-byte write enables (bit i -> bits [8i+7:8i])
//   addr_i   : word index
//   wdata_i  : write data, already lane-aligned
//   rdata_o  : asynchronous read of the addressed word
// Contents are not reset.
module lsu_dmem
    import lsu_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [3:0]            be_i,
    input  logic [DMEM_AW-1:0]    addr_i,
    input  logic [DMEM_WIDTH-1:0] wdata_i,
    output logic [DMEM_WIDTH-1:0] rdata_o
);

    logic [DMEM_WIDTH-1:0] mem_q [DMEM_DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i])
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/lsu.sv
// lsu -- load/store unit with DMEM and memory-mapped I/O registers.
//   clk_i          : clock
//   rst_ni         : synchronous reset, active HIGH (clears output registers)
//   sten_i         : store enable
//   byte_num_i     : lane mask (0001 byte, 0011 half, 1111 word, others literal)
//   addr_i         : byte address, only [11:0] decoded
//   st_data_i      : LSB-aligned store data
//   io_sw_i        : switch inputs (read at 0x900)
//   io_push_i      : push-button inputs (read at 0x910)
//   ld_data_o      : combinational load data, LSB-aligned, unselected bytes zero
//   io_ledr_o .. io_lcd_o : output peripheral registers
module lsu
    import lsu_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        sten_i,
    input  logic [3:0]  byte_num_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] st_data_i,
    input  logic [31:0] io_sw_i,
    input  logic [31:0] io_push_i,
    output logic [31:0] ld_data_o,
    output logic [31:0] io_ledr_o,
    output logic [31:0] io_ledg_o,
    output logic [31:0] io_hex0_o,
    output logic [31:0] io_hex1_o,
    output logic [31:0] io_hex2_o,
    output logic [31:0] io_hex3_o,
    output logic [31:0] io_hex4_o,
    output logic [31:0] io_hex5_o,
    output logic [31:0] io_hex6_o,
    output logic [31:0] io_hex7_o,
    output logic [31:0] io_lcd_o
);

    logic [11:0] a;
    logic [1:0]  off;
    logic [3:0]  oidx;
    region_e     rgn;
    logic        unused_addr_hi;

    assign a              = addr_i[11:0];
    assign off            = a[1:0];
    assign oidx           = a[7:4];
    assign rgn            = decode(a);
    assign unused_addr_hi = ^addr_i[31:12];

    // Lanes pushed past byte 3 fall off the top: no wrap into the next word.
    logic [6:0]  lane_wide;
    logic [3:0]  lane_mask;
    logic [31:0] wdata;
    logic        st_ok;

    assign lane_wide = {3'b000, byte_num_i} << off;
    assign lane_mask = lane_wide[3:0];
    assign wdata     = st_data_i << {off, 3'b000};
    assign st_ok     = sten_i && !rst_ni;

    // DMEM
    logic [31:0] dmem_rdata;

    lsu_dmem u_dmem (
        .clk_i   (clk_i),
        .we_i    (st_ok && (rgn == RGN_DMEM)),
        .be_i    (lane_mask),
        .addr_i  (a[10:2]),
        .wdata_i (wdata),
        .rdata_o (dmem_rdata)
    );

    // Output peripheral registers; addr[3:2] is a don't-care inside a window.
    logic [NUM_OUT-1:0][31:0] out_q, out_d;

    always_comb begin
        out_d = out_q;
        if (sten_i && rgn == RGN_OUT) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_mask[i])
                    out_d[oidx][8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni)
            out_q <= '0;
        else
            out_q <= out_d;
    end

    assign io_ledr_o = out_q[0];
    assign io_ledg_o = out_q[1];
    assign io_hex0_o = out_q[2];
    assign io_hex1_o = out_q[3];
    assign io_hex2_o = out_q[4];
    assign io_hex3_o = out_q[5];
    assign io_hex4_o = out_q[6];
    assign io_hex5_o = out_q[7];
    assign io_hex6_o = out_q[8];
    assign io_hex7_o = out_q[9];
    assign io_lcd_o  = out_q[10];

    // Load path: pick the word, align to LSB, then keep only byte_num_i lanes.
    logic [31:0] word_sel;
    logic [31:0] word_sh;
    logic [31:0] ld_mask;

    always_comb begin
        word_sel = '0;
        case (rgn)
            RGN_DMEM: word_sel = dmem_rdata;
            RGN_OUT:  word_sel = out_q[oidx];
            RGN_SW:   word_sel = io_sw_i;
            RGN_PUSH: word_sel = io_push_i;
            default:  word_sel = '0;
        endcase
    end

    always_comb begin
        ld_mask = '0;
        for (int i = 0; i < 4; i++)
            ld_mask[8*i +: 8] = {8{byte_num_i[i]}};
    end

    assign word_sh   = word_sel >> {off, 3'b000};
    assign ld_data_o = word_sh & ld_mask;

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

    logic        clk;
    logic        rst;
    logic        sten;
    logic [3:0]  byte_num;
    logic [31:0] addr;
    logic [31:0] st_data;
    logic [31:0] io_sw;
    logic [31:0] io_push;
    logic [31:0] ld_data;
    logic [31:0] io_ledr, io_ledg, io_lcd;
    logic [31:0] io_hex0, io_hex1, io_hex2, io_hex3;
    logic [31:0] io_hex4, io_hex5, io_hex6, io_hex7;

    lsu dut (
        .clk_i      (clk),
        .rst_ni     (rst),
        .sten_i     (sten),
        .byte_num_i (byte_num),
        .addr_i     (addr),
        .st_data_i  (st_data),
        .io_sw_i    (io_sw),
        .io_push_i  (io_push),
        .ld_data_o  (ld_data),
        .io_ledr_o  (io_ledr),
        .io_ledg_o  (io_ledg),
        .io_hex0_o  (io_hex0),
        .io_hex1_o  (io_hex1),
        .io_hex2_o  (io_hex2),
        .io_hex3_o  (io_hex3),
        .io_hex4_o  (io_hex4),
        .io_hex5_o  (io_hex5),
        .io_hex6_o  (io_hex6),
        .io_hex7_o  (io_hex7),
        .io_lcd_o   (io_lcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] outs [11];
    assign outs[0]  = io_ledr;
    assign outs[1]  = io_ledg;
    assign outs[2]  = io_hex0;
    assign outs[3]  = io_hex1;
    assign outs[4]  = io_hex2;
    assign outs[5]  = io_hex3;
    assign outs[6]  = io_hex4;
    assign outs[7]  = io_hex5;
    assign outs[8]  = io_hex6;
    assign outs[9]  = io_hex7;
    assign outs[10] = io_lcd;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: byte-addressed DMEM and output registers.
    logic [7:0]  bm [2048];
    logic [31:0] om [11];

    function automatic int region(input logic [31:0] ad);
        int x;
        x = int'(ad[11:0]);
        if (x < 'h800)                 return 0;
        if (x < 'h8B0)                 return 1;
        if (x >= 'h900 && x < 'h910)   return 2;
        if (x >= 'h910 && x < 'h920)   return 3;
        return 4;
    endfunction

    function automatic logic [31:0] mword(input logic [31:0] ad);
        int b;
        b = int'(ad[10:2]) * 4;
        case (region(ad))
            0: return {bm[b+3], bm[b+2], bm[b+1], bm[b]};
            1: return om[(int'(ad[11:0]) - 'h800) / 16];
            2: return io_sw;
            3: return io_push;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] mload(input logic [31:0] ad, input logic [3:0] bn);
        logic [31:0] w, r;
        int o;
        w = mword(ad);
        o = int'(ad[1:0]);
        r = '0;
        for (int j = 0; j < 4; j++)
            if (bn[j] && (o + j) < 4) r[8*j +: 8] = w[8*(o+j) +: 8];
        return r;
    endfunction

    task automatic m_store(input logic [31:0] ad, input logic [31:0] d, input logic [3:0] bn);
        int o, k, b, idx;
        o   = int'(ad[1:0]);
        b   = int'(ad[10:2]) * 4;
        idx = (int'(ad[11:0]) - 'h800) / 16;
        for (int j = 0; j < 4; j++) begin
            if (bn[j] && (o + j) < 4) begin
                k = o + j;
                case (region(ad))
                    0: bm[b+k] = d[8*j +: 8];
                    1: om[idx][8*k +: 8] = d[8*j +: 8];
                    default: ;
                endcase
            end
        end
    endtask

    task automatic do_store(input logic [31:0] ad, input logic [31:0] d, input logic [3:0] bn);
        @(negedge clk);
        sten = 1'b1; addr = ad; st_data = d; byte_num = bn;
        @(posedge clk);
        m_store(ad, d, bn);
        #1 sten = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [31:0] ad, input logic [3:0] bn,
                           input logic [31:0] exp);
        @(negedge clk);
        sten = 1'b0; addr = ad; byte_num = bn;
        exp_q.push_back(exp);
        #1 chk(tag, ld_data, exp_q.pop_front());
    endtask

    task automatic check_outs(input string tag);
        #1;
        for (int i = 0; i < 11; i++)
            chk($sformatf("%s_out%0d", tag, i), outs[i], om[i]);
    endtask

    initial begin
        logic [31:0] ra, rd;
        logic [3:0]  rb;
        sten = 0; byte_num = 4'hF; addr = 0; st_data = 0;
        io_sw = 0; io_push = 0;
        for (int i = 0; i < 11; i++) om[i] = '0;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_outs("reset");

        // word store/load
        do_store(32'h104, 32'h12345678, 4'hF);
        do_load("word_rd", 32'h104, 4'hF, 32'h12345678);

        // byte/half
        do_store(32'h104, 32'hAABBCCDD, 4'hF);
        do_store(32'h106, 32'h000000EE, 4'h1);
        do_load("byte_wr_word_rd", 32'h104, 4'hF, 32'hAAEECCDD);
        do_load("half_rd", 32'h106, 4'h3, 32'h0000AAEE);

        // load in the store cycle sees the old value until the edge
        @(negedge clk);
        sten = 1; addr = 32'h104; st_data = 32'h55667788; byte_num = 4'hF;
        #1 chk("same_cyc_old", ld_data, 32'hAAEECCDD);
        @(posedge clk);
        m_store(32'h104, 32'h55667788, 4'hF);
        #1 chk("same_cyc_new", ld_data, 32'h55667788);
        sten = 0;

        // misaligned half drops the lane past byte 3
        do_store(32'h107, 32'h0000BEEF, 4'h3);
        do_load("misal_word", 32'h104, 4'hF, 32'hEF667788);
        do_load("misal_half", 32'h107, 4'h3, 32'h000000EF);
        do_store(32'h108, 32'h01020304, 4'hF);
        do_load("no_wrap", 32'h108, 4'hF, 32'h01020304);
        do_load("literal_mask", 32'h104, 4'b0101, 32'h00660088);
        do_load("addr_hi_ignored", 32'hFFFFF104, 4'hF, 32'hEF667788);

        // output peripherals
        do_store(32'h800, 32'hDEADBEEF, 4'hF);
        #1 chk("ledr", io_ledr, 32'hDEADBEEF);
        do_load("ledr_rd", 32'h800, 4'hF, 32'hDEADBEEF);
        do_store(32'h8A0, 32'h5, 4'hF);
        #1 chk("lcd", io_lcd, 32'h00000005);
        check_outs("periph");
        do_store(32'h82D, 32'h00000077, 4'h1);
        #1 chk("hex0_alias", io_hex0, 32'h00007700);

        // inputs
        io_sw = 32'h0000F00D;
        io_push = 32'hCAFE0001;
        do_store(32'h900, 32'h1, 4'hF);
        do_load("sw_rd", 32'h900, 4'hF, 32'h0000F00D);
        do_load("push_rd", 32'h910, 4'hF, 32'hCAFE0001);
        do_load("push_byte", 32'h913, 4'h1, 32'h000000CA);

        // unmapped
        do_store(32'h8B0, 32'hFFFFFFFF, 4'hF);
        do_store(32'hA00, 32'hFFFFFFFF, 4'hF);
        check_outs("unmapped");
        do_load("unm_8b0", 32'h8B0, 4'hF, 32'h0);
        do_load("unm_a00", 32'hA00, 4'hF, 32'h0);
        do_load("unm_dmem", 32'h104, 4'hF, 32'hEF667788);

        // random mix against the model
        for (int i = 0; i < 64; i++) do_store(32'(i * 4), $urandom, 4'hF);
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 3))
                0: ra = 32'($urandom_range(0, 255));
                1: ra = 32'h800 + 32'($urandom_range(0, 'hAF));
                2: ra = 32'h900 + 32'($urandom_range(0, 'h1F));
                default: ra = 32'hB00 + 32'($urandom_range(0, 'h4FF));
            endcase
            ra[31:12] = 20'($urandom);
            case ($urandom_range(0, 3))
                0: rb = 4'h1;
                1: rb = 4'h3;
                2: rb = 4'hF;
                default: rb = 4'($urandom);
            endcase
            rd = $urandom;
            if ($urandom_range(0, 1) == 0) do_store(ra, rd, rb);
            else do_load($sformatf("rnd_ld%0d", i), ra, rb, mload(ra, rb));
        end
        check_outs("rnd");

        // reset with a simultaneous store; DMEM survives
        for (int i = 0; i < 11; i++) do_store(32'h800 + 32'(i * 16), 32'hA5A50000 + 32'(i), 4'hF);
        check_outs("preload");
        do_store(32'h104, 32'h0BADF00D, 4'hF);
        @(negedge clk);
        rst = 1; sten = 1; addr = 32'h820; st_data = 32'h12345678; byte_num = 4'hF;
        @(posedge clk);
        #1 rst = 0; sten = 0;
        for (int i = 0; i < 11; i++) om[i] = '0;
        check_outs("rst_store");
        do_load("rst_dmem_kept", 32'h104, 4'hF, 32'h0BADF00D);
        do_load("rst_hex0_rd", 32'h820, 4'hF, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Port list SHALL be (name direction width meaning):
- clk_i  in  1  sole clock, all state updates on rising edge
- rst_ni  in  1  synchronous active-high reset
- sten_i  in  1  store enable
- byte_num_i  in  4  byte-lane mask: 0001 byte, 0011 half, 1111 word
- addr_i  in  32  byte address; only [11:0] decoded
- st_data_i  in  32  store data, LSB-aligned
- io_sw_i  in  32  switch inputs
- io_push_i  in  32  push-button inputs
- ld_data_o  out  32  load data
- io_ledr_o, io_ledg_o  out  32 each  red/green LED registers
- io_hex0_o..io_hex7_o  out  32 each  seven-segment registers
- io_lcd_o  out  32  LCD register

Function
REQ-003 The memory map on addr_i[11:0] SHALL be:
- 0x000-0x7FF DMEM, 2 KiB
- 0x800 LEDR, 0x810 LEDG, 0x820-0x890 HEX0-HEX7 (16-byte stride), 0x8A0 LCD; each a 16-byte window
- 0x900 SW (read-only), 0x910 PUSH (read-only)
- all other addresses unmapped
REQ-004 addr_i[31:12] SHALL be ignored.
REQ-005 DMEM SHALL be 512 x 32-bit words indexed by addr[10:2], little-endian.
REQ-006 Effective lane mask SHALL be byte_num_i shifted left by addr[1:0].
- Lanes shifted past bit 3 SHALL be dropped; misaligned accesses never wrap into the next word.
REQ-007 Stores SHALL occur on the rising clk_i edge when sten_i=1 and reset is inactive.
- Only masked lanes of the target are written.
- Data SHALL be st_data_i shifted left by 8*addr[1:0].
REQ-008 In output peripheral windows, addr[3:2] SHALL be ignored; addr[1:0] applies the lane shift per REQ-006.
REQ-009 Stores to SW, PUSH or unmapped addresses SHALL be ignored.
REQ-010 ld_data_o SHALL be combinational from addr_i, byte_num_i and current state, with zero cycles of latency.
- Value SHALL be the selected word shifted right by 8*addr[1:0].
- Bytes outside byte_num_i are zeroed; sign extension is external.
REQ-011 Selected word SHALL be:
- DMEM word, or
- output register read-back, or
- io_sw_i / io_push_i sampled live (no synchronizer), or
- 0 when unmapped.
REQ-012 A load in the same cycle as a store to the same location SHALL return the pre-edge value until the edge, then the new value.
REQ-013 Output ports SHALL be driven directly from their registers.
REQ-014 byte_num_i values other than 0001/0011/1111 SHALL be applied literally as a lane mask.

Reset
REQ-015 Asserting rst_ni on a rising edge SHALL clear all eleven output registers to 0x00000000.
REQ-016 Reset SHALL take priority over a simultaneous store; that store is discarded.
REQ-017 Reset SHALL NOT clear DMEM; contents before the first store are undefined.
- Verification initializes or writes DMEM before reading it.

Structure
REQ-018 A shared package lsu_pkg SHALL hold:
- region base-address constants
- DMEM depth/width parameters
- byte_num encodings (BYTE, HALF, WORD)
REQ-019 DMEM SHALL be one sub-module, lsu_dmem, with:
- synchronous byte-masked write
- asynchronous read
REQ-020 Decode, peripheral registers and load mux SHALL live in lsu.

Verification
REQ-021 Word DMEM: store 0x12345678 at 0x104 with mask 1111 -> ld_data_o=0x12345678 after the edge.
REQ-022 Byte/half DMEM, in order:
- store 0xAABBCCDD at 0x104, mask 1111
- store byte 0x000000EE at 0x106, mask 0001
- word read at 0x104 -> 0xAAEECCDD
- half read at 0x106 -> 0x0000AAEE
REQ-023 Outputs: store 0xDEADBEEF at 0x800 -> io_ledr_o=0xDEADBEEF, load at 0x800 returns it.
- Store 0x5 at 0x8A0 -> io_lcd_o=0x00000005.
- Other output ports unchanged.
REQ-024 Inputs: with io_sw_i=0x0000F00D, a store of 0x1 at 0x900 is ignored -> load at 0x900 returns 0x0000F00D.
- Load at 0x910 returns io_push_i.
REQ-025 Reset:
- Write all output registers, then assert rst_ni for one edge together with sten_i=1 to 0x820 -> every io_*_o = 0.
- DMEM data is retained.
REQ-026 Unmapped: store at 0x8B0 or 0xA00 -> no state change; load at those addresses -> 0.
